// File: rtl/id_exe_stage.sv
// id_exe_stage
// Pipeline register between instruction decode (ID) and execute (EXE).
// Decoded control and operand fields are captured on the rising clock edge.
// Operand forwarding from the EXE and writeback producers is resolved in
// front of the registers, so every output is a plain flop.
//
// Flow control: there is no ready/valid handshake with the decoder. stall=1
// holds every register; flush=1 (branch taken in EXE) overwrites the stage
// with a bubble. Priority per edge is rst > flush > stall > load. valid marks
// a real instruction on the outputs; a bubble always has valid=0,
// reg_write=0 and jenable=0.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   stall, flush             hold / squash controls
//   id_*                     decoded instruction fields from ID
//   ex_rd/ex_wr/ex_result    EXE-stage producer (highest forwarding priority)
//   wb_rd/wb_wr/wb_data      writeback-stage producer
//   mux_exe .. rd, valid     registered fields driving EXE
//   bubble_count             saturating count of bubbles inserted
module id_exe_stage #(
  parameter int ARQ  = 16,
  parameter int REGW = 4,
  parameter int JW   = 13,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic            id_mux_exe,
  input  logic            id_jop_lsb,
  input  logic            id_jenable,
  input  logic            id_reg_write,
  input  logic [1:0]      id_alu_op,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic [REGW-1:0] id_rsd,
  input  logic [REGW-1:0] id_rd,
  input  logic [ARQ-1:0]  id_src1,
  input  logic [ARQ-1:0]  id_src2,
  input  logic [ARQ-1:0]  id_srcdest,
  input  logic [ARQ-1:0]  id_imm,
  input  logic [JW-1:0]   id_jaddr,
  input  logic [REGW-1:0] ex_rd,
  input  logic            ex_wr,
  input  logic [ARQ-1:0]  ex_result,
  input  logic [REGW-1:0] wb_rd,
  input  logic            wb_wr,
  input  logic [ARQ-1:0]  wb_data,
  output logic            mux_exe,
  output logic            jop_lsb,
  output logic            jenable,
  output logic            reg_write,
  output logic [1:0]      alu_op,
  output logic [ARQ-1:0]  src1,
  output logic [ARQ-1:0]  src2,
  output logic [ARQ-1:0]  srcdest,
  output logic [ARQ-1:0]  imm,
  output logic [JW-1:0]   jaddr,
  output logic [REGW-1:0] rd,
  output logic            valid,
  output logic [CNTW-1:0] bubble_count
);

  logic [ARQ-1:0]  fwd_src1;
  logic [ARQ-1:0]  fwd_src2;
  logic [ARQ-1:0]  fwd_srcdest;
  logic [CNTW-1:0] bubble_next;

  // EXE holds the younger result, so it wins over WB. Register 0 is not
  // special-cased: a write to r0 is forwarded like any other register.
  function automatic logic [ARQ-1:0] fwd_pick(
    input logic [REGW-1:0] addr,
    input logic [ARQ-1:0]  rf_val,
    input logic [REGW-1:0] e_rd,
    input logic            e_wr,
    input logic [ARQ-1:0]  e_val,
    input logic [REGW-1:0] w_rd,
    input logic            w_wr,
    input logic [ARQ-1:0]  w_val
  );
    if (e_wr && (e_rd == addr)) begin
      return e_val;
    end else if (w_wr && (w_rd == addr)) begin
      return w_val;
    end
    return rf_val;
  endfunction

  always_comb begin
    fwd_src1    = fwd_pick(id_rs1, id_src1, ex_rd, ex_wr, ex_result,
                           wb_rd, wb_wr, wb_data);
    fwd_src2    = fwd_pick(id_rs2, id_src2, ex_rd, ex_wr, ex_result,
                           wb_rd, wb_wr, wb_data);
    // srcdest is forwarded even when the immediate is selected; the EXE mux
    // decides which of the two it uses.
    fwd_srcdest = fwd_pick(id_rsd, id_srcdest, ex_rd, ex_wr, ex_result,
                           wb_rd, wb_wr, wb_data);
    // Saturate at all-ones instead of wrapping back to zero.
    bubble_next = (bubble_count == {CNTW{1'b1}}) ? bubble_count
                                                 : bubble_count + CNTW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      mux_exe   <= 1'b0;
      jop_lsb   <= 1'b0;
      jenable   <= 1'b0;
      reg_write <= 1'b0;
      alu_op    <= 2'b00;
      src1      <= '0;
      src2      <= '0;
      srcdest   <= '0;
      imm       <= '0;
      jaddr     <= '0;
      rd        <= '0;
      valid     <= 1'b0;
      if (rst) begin
        bubble_count <= '0;
      end else begin
        bubble_count <= bubble_next;
      end
    end else if (!stall) begin
      mux_exe   <= id_mux_exe;
      jop_lsb   <= id_jop_lsb;
      alu_op    <= id_alu_op;
      src1      <= fwd_src1;
      src2      <= fwd_src2;
      srcdest   <= fwd_srcdest;
      imm       <= id_imm;
      jaddr     <= id_jaddr;
      rd        <= id_rd;
      valid     <= id_valid;
      // An empty decode slot must never write the register file or jump.
      jenable   <= id_valid & id_jenable;
      reg_write <= id_valid & id_reg_write;
      if (!id_valid) begin
        bubble_count <= bubble_next;
      end
    end
  end

endmodule

// File: tb/tb_id_exe_stage.sv
module tb_id_exe_stage;
  localparam int ARQ  = 16;
  localparam int REGW = 4;
  localparam int JW   = 13;
  localparam int CNTW = 4;
  localparam int SAT  = (1 << CNTW) - 1;

  typedef struct packed {
    logic            rst;
    logic            stall;
    logic            flush;
    logic            id_valid;
    logic            id_mux_exe;
    logic            id_jop_lsb;
    logic            id_jenable;
    logic            id_reg_write;
    logic [1:0]      id_alu_op;
    logic [REGW-1:0] id_rs1;
    logic [REGW-1:0] id_rs2;
    logic [REGW-1:0] id_rsd;
    logic [REGW-1:0] id_rd;
    logic [ARQ-1:0]  id_src1;
    logic [ARQ-1:0]  id_src2;
    logic [ARQ-1:0]  id_srcdest;
    logic [ARQ-1:0]  id_imm;
    logic [JW-1:0]   id_jaddr;
    logic [REGW-1:0] ex_rd;
    logic            ex_wr;
    logic [ARQ-1:0]  ex_result;
    logic [REGW-1:0] wb_rd;
    logic            wb_wr;
    logic [ARQ-1:0]  wb_data;
  } in_t;

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic            jenable;
    logic            jop_lsb;
    logic            mux_exe;
    logic [1:0]      alu_op;
    logic [ARQ-1:0]  src1;
    logic [ARQ-1:0]  src2;
    logic [ARQ-1:0]  srcdest;
    logic [ARQ-1:0]  imm;
    logic [JW-1:0]   jaddr;
    logic [REGW-1:0] rd;
    logic [CNTW-1:0] bubble_count;
  } out_t;

  localparam int OW = $bits(out_t);

  typedef struct {
    in_t  in;
    out_t exp;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  in_t  cur;
  out_t dut_o;

  logic            mux_exe, jop_lsb, jenable, reg_write, valid;
  logic [1:0]      alu_op;
  logic [ARQ-1:0]  src1, src2, srcdest, imm;
  logic [JW-1:0]   jaddr;
  logic [REGW-1:0] rd;
  logic [CNTW-1:0] bubble_count;

  assign dut_o = {valid, reg_write, jenable, jop_lsb, mux_exe, alu_op,
                  src1, src2, srcdest, imm, jaddr, rd, bubble_count};

  id_exe_stage #(.ARQ(ARQ), .REGW(REGW), .JW(JW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(cur.rst), .stall(cur.stall), .flush(cur.flush),
    .id_valid(cur.id_valid), .id_mux_exe(cur.id_mux_exe),
    .id_jop_lsb(cur.id_jop_lsb), .id_jenable(cur.id_jenable),
    .id_reg_write(cur.id_reg_write), .id_alu_op(cur.id_alu_op),
    .id_rs1(cur.id_rs1), .id_rs2(cur.id_rs2), .id_rsd(cur.id_rsd),
    .id_rd(cur.id_rd), .id_src1(cur.id_src1), .id_src2(cur.id_src2),
    .id_srcdest(cur.id_srcdest), .id_imm(cur.id_imm),
    .id_jaddr(cur.id_jaddr), .ex_rd(cur.ex_rd), .ex_wr(cur.ex_wr),
    .ex_result(cur.ex_result), .wb_rd(cur.wb_rd), .wb_wr(cur.wb_wr),
    .wb_data(cur.wb_data),
    .mux_exe(mux_exe), .jop_lsb(jop_lsb), .jenable(jenable),
    .reg_write(reg_write), .alu_op(alu_op), .src1(src1), .src2(src2),
    .srcdest(srcdest), .imm(imm), .jaddr(jaddr), .rd(rd), .valid(valid),
    .bubble_count(bubble_count)
  );

  // scoreboard
  logic [OW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  // reference model state: what EXE should currently see, plus an
  // unbounded bubble tally that is clamped when presented
  out_t m_o;
  int   m_bub;

  // newest producer first; the first one writing the same register wins
  function automatic logic [ARQ-1:0] ref_operand(input in_t i,
      input logic [REGW-1:0] addr, input logic [ARQ-1:0] rf_val);
    logic [REGW-1:0] p_rd[2];
    logic            p_wr[2];
    logic [ARQ-1:0]  p_val[2];
    p_rd[0] = i.ex_rd; p_wr[0] = i.ex_wr; p_val[0] = i.ex_result;
    p_rd[1] = i.wb_rd; p_wr[1] = i.wb_wr; p_val[1] = i.wb_data;
    for (int k = 0; k < 2; k++) begin
      if (p_wr[k] && p_rd[k] == addr) return p_val[k];
    end
    return rf_val;
  endfunction

  task automatic model_edge(input in_t i);
    if (i.rst) begin
      m_o   = '0;
      m_bub = 0;
    end else if (i.flush) begin
      m_o   = '0;
      m_bub = m_bub + 1;
    end else if (!i.stall) begin
      m_o.valid     = i.id_valid;
      m_o.reg_write = i.id_valid ? i.id_reg_write : 1'b0;
      m_o.jenable   = i.id_valid ? i.id_jenable : 1'b0;
      m_o.jop_lsb   = i.id_jop_lsb;
      m_o.mux_exe   = i.id_mux_exe;
      m_o.alu_op    = i.id_alu_op;
      m_o.src1      = ref_operand(i, i.id_rs1, i.id_src1);
      m_o.src2      = ref_operand(i, i.id_rs2, i.id_src2);
      m_o.srcdest   = ref_operand(i, i.id_rsd, i.id_srcdest);
      m_o.imm       = i.id_imm;
      m_o.jaddr     = i.id_jaddr;
      m_o.rd        = i.id_rd;
      if (!i.id_valid) m_bub = m_bub + 1;
    end
    m_o.bubble_count = CNTW'((m_bub > SAT) ? SAT : m_bub);
  endtask

  task automatic check(input string name, input logic [OW-1:0] got,
                       input logic [OW-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", name, got, want);
    end
  endtask

  // driver: apply one input set across one rising edge, then score
  task automatic step(input in_t i, input string name);
    cur = i;
    @(posedge clk);
    model_edge(i);
    exp_q.push_back(m_o);
    #1;
    check(name, dut_o, exp_q.pop_front());
  endtask

  function automatic in_t base_in();
    in_t b;
    b = '0;
    b.id_valid = 1'b1; b.id_reg_write = 1'b1; b.id_alu_op = 2'b01;
    b.id_rs1 = 4'd1; b.id_rs2 = 4'd2; b.id_rsd = 4'd3; b.id_rd = 4'd4;
    b.id_src1 = 16'h0003; b.id_src2 = 16'h0004; b.id_srcdest = 16'h0005;
    b.id_imm = 16'h00F0; b.id_jaddr = 13'h0ABC;
    b.ex_rd = 4'd8; b.wb_rd = 4'd9;
    return b;
  endfunction

  function automatic out_t base_exp();
    out_t e;
    e = '0;
    e.valid = 1'b1; e.reg_write = 1'b1; e.alu_op = 2'b01;
    e.src1 = 16'h0003; e.src2 = 16'h0004; e.srcdest = 16'h0005;
    e.imm = 16'h00F0; e.jaddr = 13'h0ABC; e.rd = 4'd4;
    return e;
  endfunction

  function automatic in_t rand_in();
    in_t r;
    r = '0;
    r.rst          = ($urandom_range(0, 49) == 0);
    r.flush        = ($urandom_range(0, 5) == 0);
    r.stall        = ($urandom_range(0, 3) == 0);
    r.id_valid     = ($urandom_range(0, 3) != 0);
    r.id_mux_exe   = 1'($urandom);
    r.id_jop_lsb   = 1'($urandom);
    r.id_jenable   = 1'($urandom);
    r.id_reg_write = 1'($urandom);
    r.id_alu_op    = 2'($urandom);
    r.id_rs1       = 4'($urandom_range(0, 3));
    r.id_rs2       = 4'($urandom_range(0, 3));
    r.id_rsd       = 4'($urandom_range(0, 3));
    r.id_rd        = 4'($urandom);
    r.id_src1      = 16'($urandom);
    r.id_src2      = 16'($urandom);
    r.id_srcdest   = 16'($urandom);
    r.id_imm       = 16'($urandom);
    r.id_jaddr     = 13'($urandom);
    r.ex_rd        = 4'($urandom_range(0, 3));
    r.ex_wr        = 1'($urandom);
    r.ex_result    = 16'($urandom);
    r.wb_rd        = 4'($urandom_range(0, 3));
    r.wb_wr        = 1'($urandom);
    r.wb_data      = 16'($urandom);
    return r;
  endfunction

  vec_t vecs[7];
  in_t  t;
  out_t zero_o;

  initial begin
    // table: each row is a load from a known state, expectations by hand
    vecs[0].in = base_in();
    vecs[0].exp = base_exp();

    vecs[1].in = base_in();
    vecs[1].in.id_rs1 = 4'd5; vecs[1].in.id_src1 = 16'h0AAA;
    vecs[1].in.ex_rd = 4'd5; vecs[1].in.ex_wr = 1'b1;
    vecs[1].in.ex_result = 16'h1111;
    vecs[1].in.wb_rd = 4'd5; vecs[1].in.wb_wr = 1'b1;
    vecs[1].in.wb_data = 16'h2222;
    vecs[1].exp = base_exp(); vecs[1].exp.src1 = 16'h1111;

    vecs[2].in = vecs[1].in; vecs[2].in.ex_wr = 1'b0;
    vecs[2].exp = base_exp(); vecs[2].exp.src1 = 16'h2222;

    vecs[3].in = vecs[2].in; vecs[3].in.wb_wr = 1'b0;
    vecs[3].exp = base_exp(); vecs[3].exp.src1 = 16'h0AAA;

    vecs[4].in = base_in();
    vecs[4].in.id_rs1 = 4'd0; vecs[4].in.id_rsd = 4'd0;
    vecs[4].in.id_rs2 = 4'd9; vecs[4].in.id_rd = 4'd0;
    vecs[4].in.ex_rd = 4'd0; vecs[4].in.ex_wr = 1'b1;
    vecs[4].in.ex_result = 16'hBEEF;
    vecs[4].in.wb_rd = 4'd9; vecs[4].in.wb_wr = 1'b1;
    vecs[4].in.wb_data = 16'h7777;
    vecs[4].in.id_mux_exe = 1'b1; vecs[4].in.id_imm = 16'h1234;
    vecs[4].in.id_jop_lsb = 1'b1; vecs[4].in.id_jenable = 1'b1;
    vecs[4].in.id_alu_op = 2'b10;
    vecs[4].exp = base_exp();
    vecs[4].exp.src1 = 16'hBEEF; vecs[4].exp.srcdest = 16'hBEEF;
    vecs[4].exp.src2 = 16'h7777; vecs[4].exp.imm = 16'h1234;
    vecs[4].exp.mux_exe = 1'b1; vecs[4].exp.jop_lsb = 1'b1;
    vecs[4].exp.jenable = 1'b1; vecs[4].exp.alu_op = 2'b10;
    vecs[4].exp.rd = 4'd0;

    vecs[5].in = base_in();
    vecs[5].in.id_valid = 1'b0; vecs[5].in.id_jenable = 1'b1;
    vecs[5].exp = base_exp();
    vecs[5].exp.valid = 1'b0; vecs[5].exp.reg_write = 1'b0;
    vecs[5].exp.jenable = 1'b0; vecs[5].exp.bubble_count = 4'd1;

    vecs[6].in = base_in();
    vecs[6].in.ex_rd = 4'd2; vecs[6].in.ex_wr = 1'b1;
    vecs[6].in.ex_result = 16'h3333;
    vecs[6].in.wb_rd = 4'd3; vecs[6].in.wb_wr = 1'b1;
    vecs[6].in.wb_data = 16'h4444;
    vecs[6].exp = base_exp();
    vecs[6].exp.src2 = 16'h3333; vecs[6].exp.srcdest = 16'h4444;
    vecs[6].exp.bubble_count = 4'd1;

    zero_o = '0;
    m_o    = '0;
    m_bub  = 0;

    // reset held 2 cycles with a live instruction and stall asserted
    t = base_in(); t.rst = 1'b1; t.stall = 1'b1;
    cur = t;
    for (int k = 0; k < 2; k++) begin
      step(t, "reset");
      check("reset_zero", dut_o, zero_o);
    end

    // table-driven loads
    for (int k = 0; k < 7; k++) begin
      step(vecs[k].in, $sformatf("vec%0d_model", k));
      check($sformatf("vec%0d", k), dut_o, vecs[k].exp);
    end

    // stall: A loaded, then B presented under stall for 3 cycles
    t = base_in(); t.id_imm = 16'hAAAA;
    step(t, "stall_load_a");
    for (int k = 0; k < 3; k++) begin
      t = base_in(); t.id_imm = 16'hBBBB; t.stall = 1'b1;
      step(t, "stall_hold");
      check_int("stall_hold_imm", int'(imm), 16'hAAAA);
    end
    t.stall = 1'b0;
    step(t, "stall_release");
    check_int("stall_release_imm", int'(imm), 16'hBBBB);
    check_int("stall_bubble_same", int'(bubble_count), 1);

    // flush beats stall
    t = base_in(); t.stall = 1'b1; t.flush = 1'b1; t.id_jenable = 1'b1;
    step(t, "flush");
    check_int("flush_ctrl", int'({valid, reg_write, jenable}), 0);
    check_int("flush_bubble", int'(bubble_count), 2);

    // saturation: 20 more bubbles on top of 2
    t = base_in(); t.flush = 1'b1;
    for (int k = 0; k < 20; k++) step(t, "sat_flush");
    check_int("sat_bubble", int'(bubble_count), SAT);

    // reset in the middle of a stall drops the held instruction
    t = base_in();
    step(t, "rms_load");
    t.stall = 1'b1;
    step(t, "rms_stall");
    t.rst = 1'b1;
    step(t, "rms_reset");
    check("rms_zero", dut_o, zero_o);

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      step(rand_in(), "random");
    end

    check_int("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_exe_stage.md
Name: id_exe_stage

Overview:
Pipeline register between instruction decode and the EXE stage. It captures decoded control and operand fields and applies operand forwarding from the EXE and writeback stages at capture time. It supports stall (hold) and flush (bubble insert on taken branch) and drives EXE inputs directly from registers. A saturating bubble counter is provided for performance debug.

Parameters:
ARQ, 16, datapath width (matches EXE)
REGW, 4, register-file address width
JW, 13, jump address width
CNTW, 16, bubble counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
stall  in  1  hold current contents
flush  in  1  branch_taken from EXE; squash the instruction being captured
id_valid  in  1  decode slot holds a real instruction
id_mux_exe, id_jop_lsb, id_jenable, id_reg_write  in  1 each  decoded controls
id_alu_op  in  2  decoded ALU op
id_rs1, id_rs2, id_rsd, id_rd  in  REGW each  source/dest register addresses
id_src1, id_src2, id_srcdest  in  ARQ each  register-file read data
id_imm  in  ARQ  extended immediate
id_jaddr  in  JW  jump target
ex_rd  in  REGW; ex_wr  in  1; ex_result  in  ARQ  EXE-stage producer
wb_rd  in  REGW; wb_wr  in  1; wb_data  in  ARQ  writeback-stage producer
mux_exe, jop_lsb, jenable, reg_write  out  1 each  to EXE / later stages
alu_op  out  2
src1, src2, srcdest, imm  out  ARQ each
jaddr  out  JW
rd  out  REGW
valid  out  1
bubble_count  out  CNTW  saturating count of bubbles inserted

Behaviour:
- All outputs are registers. Latency: one cycle from id_* to outputs.
- Reset (rst=1 at edge): every output is 0, including valid, reg_write, jenable, and bubble_count. Reset overrides flush and stall. Reset mid-stall drops the held instruction.
- Priority per edge: rst > flush > stall > load.
- flush=1: load a bubble. All control outputs (valid, reg_write, jenable, jop_lsb, mux_exe, alu_op) are 0. Data outputs are 0. bubble_count is incremented.
- stall=1, flush=0: all outputs hold. bubble_count is unchanged.
- Load (stall=0, flush=0): capture all id_* fields. valid=id_valid.
  - If id_valid=0, reg_write and jenable are forced to 0, and bubble_count is incremented.
- Forwarding applies independently to each of src1/src2/srcdest, using operand addresses id_rs1/id_rs2/id_rsd:
  - if ex_wr and ex_rd==addr: take ex_result;
  - else if wb_wr and wb_rd==addr: take wb_data;
  - else: take the id_* register-file value.
  - EXE has priority over WB when both match.
  - Register 0 is ordinary and is forwarded like any other register.
- Forwarding does not alter imm. srcdest is forwarded even when id_mux_exe selects imm. The EXE mux chooses between them.
- bubble_count saturates at 2^CNTW-1 and does not wrap.
- Combinational paths: none from inputs to outputs. Forwarding muxes feed the register D inputs only.
- Stall and flush both high: flush wins and a bubble is inserted.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with id_valid=1 and stall=1 -> all outputs 0, bubble_count=0; first load after release passes id_* fields through.
2. Plain load: id_valid=1, alu_op=2'b01, id_src1=16'h0003, id_imm=16'h00F0, id_jaddr=13'h0ABC, no forwarding match -> next cycle src1=0003, imm=00F0, jaddr=0ABC, valid=1.
3. Forward priority: id_rs1=4'd5, ex_wr=1, ex_rd=5, ex_result=16'h1111, wb_wr=1, wb_rd=5, wb_data=16'h2222 -> src1=1111. Drop ex_wr -> src1=2222. Drop both -> src1=id_src1.
4. Stall: load instruction A, then stall=1 for 3 cycles while id_* change to B -> outputs stay A. Release -> B appears one cycle later. bubble_count is unchanged.
5. Flush: stall=1 and flush=1 with id_valid=1, reg_write=1, jenable=1 -> valid=0, reg_write=0, jenable=0, bubble_count increments by 1.
6. Saturation: force 2^CNTW+3 flush cycles (or CNTW=4 in the bench) -> bubble_count stops at 2^CNTW-1.
